cfg_stream_loader: RTL
======================

Name: cfg_stream_loader

Overview:
- Serial configuration front-end sitting directly upstream of the fpga fabric.
- Receives the configuration bitstream on a serial line and stages it in a shadow buffer.
- Verifies a checksum, then commits the staged words one per cycle to the fabric's configuration registers (LUT mem words, switch-box configure words).
- Replaces the bench-side hierarchical loading of the fabric's configuration registers with a hardware load path.

Parameters:
- NUM_WORDS, 10, number of configuration words per frame (fabric config image size)
- WORD_W, 32, width of one configuration word; must be a multiple of 8
- ADDR_W, 4, width of cfg_addr; must satisfy NUM_WORDS <= 2**ADDR_W

Ports:
- clock  input  1  single system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse: begin (or restart) a load
- sin  input  1  serial configuration data, MSB first
- sen  input  1  serial enable; sin is sampled only on edges where sen=1
- cfg_we  output  1  write strobe to fabric configuration registers
- cfg_addr  output  ADDR_W  configuration word index being written
- cfg_data  output  WORD_W  configuration word being written
- busy  output  1  high in SYNC, LOAD, CHECK and COMMIT
- cfg_done  output  1  load committed successfully; sticky until next start or reset
- cfg_error  output  1  checksum mismatch; sticky until next start or reset
- word_count  output  ADDR_W  number of words received into the shadow buffer in the current frame

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0: cfg_we, cfg_addr, cfg_data, busy, cfg_done, cfg_error, word_count.
  - Shadow buffer, bit counter, sync shift register and checksum accumulator cleared.
  - Reset during any state, including COMMIT, drops cfg_we immediately; no further writes are issued.
- Frame format on sin, counting only sen=1 samples:
  - 8-bit sync 0xA5.
  - NUM_WORDS words of WORD_W bits each, MSB first, word 0 first.
  - 8-bit checksum equal to the XOR of every byte of every word.
- State machine:
  - IDLE: busy=0. start -> SYNC.
  - SYNC: 8-bit sliding shift register on sampled bits. On the edge where it equals 0xA5 -> LOAD. The sync bits are excluded from the checksum. No timeout.
  - LOAD: shift sampled bits into the word register. On the WORD_W-th bit:
    - write the word to shadow[word_count];
    - XOR its bytes into the checksum accumulator;
    - increment word_count and reset the bit counter.
    - When word_count reaches NUM_WORDS -> CHECK.
  - CHECK: shift in 8 checksum bits.
    - On the 8th sampled bit, match -> COMMIT, mismatch -> ERROR.
    - The comparison includes the final bit, so the decision is made on that same edge.
  - COMMIT: cfg_we=1 for exactly NUM_WORDS consecutive cycles, ignoring sin and sen.
    - cfg_addr steps 0,1,...,NUM_WORDS-1; cfg_data = shadow[cfg_addr].
    - The first cfg_we cycle begins on the edge after the edge sampling the last checksum bit.
    - After the write at address NUM_WORDS-1 -> DONE.
  - DONE: cfg_done=1, cfg_we=0, busy=0. Holds until start.
  - ERROR: cfg_error=1, busy=0, no cfg_we ever asserted for this frame. Holds until start.
- start priority:
  - start in any state (including mid-LOAD and mid-COMMIT) forces SYNC on the next edge.
  - It clears cfg_done, cfg_error, word_count, the bit counter and the checksum, and deasserts cfg_we.
  - A sin bit sampled on the same edge as start is discarded.
- sen=0 on any edge: no shift, counters hold. Gaps of arbitrary length are legal anywhere in SYNC, LOAD and CHECK.
- cfg_addr and cfg_data hold their last values outside COMMIT. They are meaningful only while cfg_we=1.
- Fabric registers are never written with partial or unverified data.

Test Plan:
- Good frame: start; sync 0xA5; word0=0x12345678, words1..9=0; checksum 0x08 -> busy=1 through the frame; 10 consecutive cfg_we cycles starting one edge after the last checksum bit; addr 0 data 0x12345678, addrs 1..9 data 0; then cfg_done=1, busy=0.
- Bad checksum: same frame with checksum 0x09 -> cfg_error=1, cfg_done=0, cfg_we never asserted, word_count=10.
- Sen gaps and sync search: 13 garbage bits, including the partial pattern 1010010, then 0xA5 and a valid frame with random sen=0 gaps of 1-5 cycles -> identical writes and cfg_done=1 as in the good-frame case.
- Restart mid-load: start pulse after 3 words, then a full valid frame with word0=0xFFF0F000 and checksum 0xFF -> no cfg_we before the second frame completes; word_count restarts from 0; the committed data equals the second frame only.
- Reset mid-commit: assert reset_n=0 during the 4th cfg_we cycle -> cfg_we=0 immediately (asynchronously); all outputs 0; state IDLE; no writes after reset release until a new start and a valid frame.
- Back-to-back loads: after cfg_done, start plus a second valid frame -> cfg_done clears on the start edge, busy=1, then 10 new writes and cfg_done=1 again.

Source files
------------

// File: rtl/cfg_stream_loader.sv
// Serial configuration loader: sync search, shadow staging, checksum verify, then a
// one-word-per-cycle commit burst into the fabric configuration registers.
module cfg_stream_loader #(
  parameter int unsigned NUM_WORDS = 10,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sin,
  input  logic              sen,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [WORD_W-1:0] cfg_data,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [ADDR_W-1:0] word_count
);

  localparam int unsigned CntW     = (WORD_W > 8) ? $clog2(WORD_W) : 3;
  localparam int unsigned IdxW     = ADDR_W + 1;
  localparam int unsigned NumBytes = WORD_W / 8;

  localparam logic [7:0]        SyncPat   = 8'hA5;
  localparam logic [CntW-1:0]   WordLast  = CntW'(WORD_W - 1);
  localparam logic [CntW-1:0]   CsumLast  = CntW'(7);
  localparam logic [ADDR_W-1:0] LastWord  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [IdxW-1:0]   CommitEnd = IdxW'(NUM_WORDS);

  typedef enum logic [2:0] {
    StIdle, StSync, StLoad, StCheck, StCommit, StDone, StError
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        sync_q, sync_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        chk_q, chk_d;
  logic [IdxW-1:0]   commit_idx_q, commit_idx_d;
  logic              cfg_we_q, cfg_we_d;
  logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
  logic [WORD_W-1:0] cfg_data_q, cfg_data_d;
  logic              shadow_we;
  logic [WORD_W-1:0] shadow_q [NUM_WORDS];

  function automatic logic [7:0] xor_bytes(input logic [WORD_W-1:0] w);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      r = r ^ w[i*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    sync_d       = sync_q;
    word_d       = word_q;
    bit_cnt_d    = bit_cnt_q;
    word_count_d = word_count_q;
    csum_d       = csum_q;
    chk_d        = chk_q;
    commit_idx_d = commit_idx_q;
    cfg_we_d     = 1'b0;
    cfg_addr_d   = cfg_addr_q;
    cfg_data_d   = cfg_data_q;
    shadow_we    = 1'b0;

    if (start) begin
      // Restart wins over everything; the bit sampled on this edge is dropped.
      state_d      = StSync;
      sync_d       = '0;
      word_d       = '0;
      bit_cnt_d    = '0;
      word_count_d = '0;
      csum_d       = '0;
      chk_d        = '0;
      commit_idx_d = '0;
    end else begin
      unique case (state_q)
        StSync: begin
          if (sen) begin
            sync_d = {sync_q[6:0], sin};
            if (sync_d == SyncPat) begin
              state_d   = StLoad;
              bit_cnt_d = '0;
              word_d    = '0;
            end
          end
        end
        StLoad: begin
          if (sen) begin
            word_d    = {word_q[WORD_W-2:0], sin};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == WordLast) begin
              shadow_we    = 1'b1;
              csum_d       = csum_q ^ xor_bytes(word_d);
              word_count_d = word_count_q + 1'b1;
              bit_cnt_d    = '0;
              if (word_count_q == LastWord) begin
                state_d = StCheck;
              end
            end
          end
        end
        StCheck: begin
          if (sen) begin
            chk_d     = {chk_q[6:0], sin};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CsumLast) begin
              bit_cnt_d = '0;
              if (chk_d == csum_q) begin
                state_d      = StCommit;
                commit_idx_d = '0;
              end else begin
                state_d = StError;
              end
            end
          end
        end
        StCommit: begin
          // Writes are registered, so the burst trails the state by one cycle.
          if (commit_idx_q == CommitEnd) begin
            state_d = StDone;
          end else begin
            cfg_we_d     = 1'b1;
            cfg_addr_d   = commit_idx_q[ADDR_W-1:0];
            cfg_data_d   = shadow_q[commit_idx_q[ADDR_W-1:0]];
            commit_idx_d = commit_idx_q + 1'b1;
          end
        end
        StIdle, StDone, StError: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      sync_q       <= '0;
      word_q       <= '0;
      bit_cnt_q    <= '0;
      word_count_q <= '0;
      csum_q       <= '0;
      chk_q        <= '0;
      commit_idx_q <= '0;
      cfg_we_q     <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      word_q       <= word_d;
      bit_cnt_q    <= bit_cnt_d;
      word_count_q <= word_count_d;
      csum_q       <= csum_d;
      chk_q        <= chk_d;
      commit_idx_q <= commit_idx_d;
      cfg_we_q     <= cfg_we_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_data_q   <= cfg_data_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (shadow_we) begin
      shadow_q[word_count_q] <= word_d;
    end
  end

  assign cfg_we     = cfg_we_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_data   = cfg_data_q;
  assign word_count = word_count_q;
  assign busy       = (state_q == StSync) || (state_q == StLoad) ||
                      (state_q == StCheck) || (state_q == StCommit);
  assign cfg_done   = (state_q == StDone);
  assign cfg_error  = (state_q == StError);

endmodule
